// File: rtl/mem_align_unit_if.sv
// mem_align_unit_if: EX/MEM request/response and word-wide data-memory signals of the alignment stage.
interface mem_align_unit_if #(parameter int ADDR_W = 9);
  logic              req_valid;
  logic              req_ready;
  logic              mem_read;
  logic              mem_write;
  logic [2:0]        funct3;
  logic [31:0]       addr;
  logic [31:0]       wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_misalign;
  logic [ADDR_W-1:0] dm_addr;
  logic [31:0]       dm_wdata;
  logic [3:0]        dm_be;
  logic              dm_we;
  logic              dm_re;
  logic [31:0]       dm_rdata;
  modport slave (
    input  req_valid, mem_read, mem_write, funct3, addr, wdata, dm_rdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_misalign, dm_addr, dm_wdata, dm_be, dm_we, dm_re
  );
  modport master (
    output req_valid, mem_read, mem_write, funct3, addr, wdata, dm_rdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_misalign, dm_addr, dm_wdata, dm_be, dm_we, dm_re
  );
endinterface

// File: rtl/mem_align_unit.sv
// mem_align_unit: load/store alignment stage; splits word-crossing accesses and extends load data.
module mem_align_unit #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 9,
  parameter int SPLIT_EN = 1
) (
  input logic clk,
  input logic reset,
  mem_align_unit_if.slave bus
);
  typedef enum logic [2:0] {IDLE, ACC0, WAIT0, ACC1, WAIT1, RESP} state_t;
  state_t              state;
  logic                st;
  logic [2:0]          f3;
  logic [1:0]          o;
  logic [ADDR_W-1:0]   wa;
  logic [7:0]          m;
  logic [2*DATA_W-1:0] sd, mw;
  logic [DATA_W-1:0]   w0, lr, ext;
  logic [3:0]          bm;
  logic                split, drop;
  assign bus.req_ready = state == IDLE;
  always_comb begin
    bm    = (bus.mem_write ? bus.funct3 == 3'b000 : bus.funct3[1:0] == 2'b00) ? 4'b0001 :
            (bus.mem_write ? bus.funct3 == 3'b001 : bus.funct3[1:0] == 2'b01) ? 4'b0011 : 4'b1111;
    split = |m[7:4];
    drop  = split && (SPLIT_EN == 0);
    // The most recently read word is still live on dm_rdata in RESP, so only word0 is kept.
    mw    = split ? {bus.dm_rdata, w0} : {{DATA_W{1'b0}}, bus.dm_rdata};
    lr    = DATA_W'(mw >> {o, 3'b000});
    ext   = f3 == 3'b000 ? {{24{lr[7]}}, lr[7:0]} :
            f3 == 3'b001 ? {{16{lr[15]}}, lr[15:0]} :
            f3 == 3'b100 ? {24'b0, lr[7:0]} :
            f3 == 3'b101 ? {16'b0, lr[15:0]} : lr;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      st               <= 1'b0;
      f3               <= 3'b0;
      o                <= 2'b0;
      wa               <= '0;
      m                <= 8'b0;
      sd               <= '0;
      w0               <= '0;
      bus.rsp_valid    <= 1'b0;
      bus.rsp_rdata    <= '0;
      bus.rsp_misalign <= 1'b0;
      bus.dm_addr      <= '0;
      bus.dm_wdata     <= '0;
      bus.dm_be        <= 4'b0;
      bus.dm_we        <= 1'b0;
      bus.dm_re        <= 1'b0;
    end else begin
      bus.dm_we     <= 1'b0;
      bus.dm_re     <= 1'b0;
      bus.dm_be     <= 4'b0;
      bus.rsp_valid <= 1'b0;
      case (state)
        IDLE: if (bus.req_valid && (bus.mem_read || bus.mem_write)) begin
          st    <= bus.mem_write;
          f3    <= bus.funct3;
          o     <= bus.addr[1:0];
          wa    <= bus.addr[ADDR_W+1:2];
          m     <= {4'b0, bm} << bus.addr[1:0];
          sd    <= {{DATA_W{1'b0}}, bus.wdata} << {bus.addr[1:0], 3'b000};
          state <= ACC0;
        end
        ACC0: begin
          if (!drop) begin
            bus.dm_addr  <= wa;
            bus.dm_we    <= st;
            bus.dm_re    <= !st;
            bus.dm_be    <= st ? m[3:0] : 4'b0;
            bus.dm_wdata <= sd[DATA_W-1:0];
          end
          state <= drop ? RESP : !st ? WAIT0 : split ? ACC1 : RESP;
        end
        WAIT0: state <= split ? ACC1 : RESP;
        ACC1: begin
          w0           <= bus.dm_rdata;
          bus.dm_addr  <= wa + ADDR_W'(1);
          bus.dm_we    <= st;
          bus.dm_re    <= !st;
          bus.dm_be    <= st ? m[7:4] : 4'b0;
          bus.dm_wdata <= sd[2*DATA_W-1:DATA_W];
          state        <= st ? RESP : WAIT1;
        end
        WAIT1: state <= RESP;
        RESP: begin
          bus.rsp_valid    <= 1'b1;
          bus.rsp_misalign <= split;
          bus.rsp_rdata    <= (st || drop) ? '0 : ext;
          state            <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_mem_align_unit.sv
// tb_mem_align_unit: table-driven directed checks of mem_align_unit plus multi-cycle corner sequences.
module tb_mem_align_unit;
  logic clk = 1'b0, reset = 1'b1;
  logic va = 1'b0, vb = 1'b0, mr = 1'b0, mwr = 1'b0, sel = 1'b0;
  logic [2:0] f3 = 3'b0;
  logic [31:0] addr = '0, wdata = '0, rd;
  logic [31:0] mem [512];
  int n_cmp = 0, n_bad = 0;
  int r_lat, r_n, r_low;
  logic [31:0] r_rdata, r_a [2], r_d [2];
  logic [3:0] r_be [2];
  logic r_mis;
  mem_align_unit_if #(.ADDR_W(9)) ia ();
  mem_align_unit_if #(.ADDR_W(9)) ib ();
  mem_align_unit #(.DATA_W(32), .ADDR_W(9), .SPLIT_EN(1)) u0 (.clk(clk), .reset(reset), .bus(ia.slave));
  mem_align_unit #(.DATA_W(32), .ADDR_W(9), .SPLIT_EN(0)) u1 (.clk(clk), .reset(reset), .bus(ib.slave));
  always #5 clk = ~clk;
  assign ia.req_valid = va;
  assign ib.req_valid = vb;
  assign ia.mem_read = mr;
  assign ib.mem_read = mr;
  assign ia.mem_write = mwr;
  assign ib.mem_write = mwr;
  assign ia.funct3 = f3;
  assign ib.funct3 = f3;
  assign ia.addr = addr;
  assign ib.addr = addr;
  assign ia.wdata = wdata;
  assign ib.wdata = wdata;
  assign ia.dm_rdata = rd;
  assign ib.dm_rdata = '0;
  wire        s_rv    = sel ? ib.rsp_valid : ia.rsp_valid;
  wire        s_mis   = sel ? ib.rsp_misalign : ia.rsp_misalign;
  wire [31:0] s_rdata = sel ? ib.rsp_rdata : ia.rsp_rdata;
  wire        s_ready = sel ? ib.req_ready : ia.req_ready;
  wire        s_we    = sel ? ib.dm_we : ia.dm_we;
  wire        s_re    = sel ? ib.dm_re : ia.dm_re;
  wire [8:0]  s_addr  = sel ? ib.dm_addr : ia.dm_addr;
  wire [3:0]  s_be    = sel ? ib.dm_be : ia.dm_be;
  wire [31:0] s_wd    = sel ? ib.dm_wdata : ia.dm_wdata;
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 512; i++) mem[i] <= '0;
      mem[0]   <= 32'h88776655;
      mem[3]   <= 32'h00EE0000;
      mem[4]   <= 32'hDEADBEEF;
      mem[511] <= 32'h44332211;
    end else begin
      if (ia.dm_we)
        for (int j = 0; j < 4; j++)
          if (ia.dm_be[j]) mem[ia.dm_addr][8*j +: 8] <= ia.dm_wdata[8*j +: 8];
      if (ia.dm_re) rd <= mem[ia.dm_addr];
    end
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic run(input logic s, input logic wr, input logic [2:0] f, input logic [31:0] ad, input logic [31:0] wd);
    @(negedge clk);
    sel = s; mwr = wr; mr = !wr; f3 = f; addr = ad; wdata = wd;
    if (s) vb = 1'b1; else va = 1'b1;
    @(posedge clk); #1;
    va = 1'b0; vb = 1'b0;
    r_low = s_ready ? 0 : 1; r_n = 0; r_lat = -1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk); #1;
      if (s_re || s_we) begin
        if (r_n < 2) begin r_a[r_n] = 32'(s_addr); r_be[r_n] = s_be; r_d[r_n] = s_wd; end
        r_n++;
      end
      if (!s_ready) r_low++;
      if (s_rv) begin r_lat = k; r_rdata = s_rdata; r_mis = s_mis; break; end
    end
    if (r_lat < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL timeout: no rsp_valid within 20 cycles for addr %h", ad);
    end
  endtask
  typedef struct {
    logic wr; logic [2:0] f3; logic [31:0] addr, wdata, rdata; logic mis; int lat, n, a0, a1;
  } vec_t;
  vec_t tv [19];
  initial begin
    tv[0]  = '{1'b0, 3'b010, 32'h010, 32'h0,        32'hDEADBEEF, 1'b0, 3, 1, 4,   0};
    tv[1]  = '{1'b1, 3'b010, 32'h010, 32'h80112233, 32'h0,        1'b0, 2, 1, 4,   0};
    tv[2]  = '{1'b0, 3'b000, 32'h013, 32'h0,        32'hFFFFFF80, 1'b0, 3, 1, 4,   0};
    tv[3]  = '{1'b0, 3'b100, 32'h013, 32'h0,        32'h00000080, 1'b0, 3, 1, 4,   0};
    tv[4]  = '{1'b0, 3'b001, 32'h012, 32'h0,        32'hFFFF8011, 1'b0, 3, 1, 4,   0};
    tv[5]  = '{1'b0, 3'b101, 32'h010, 32'h0,        32'h00002233, 1'b0, 3, 1, 4,   0};
    tv[6]  = '{1'b1, 3'b001, 32'h00F, 32'h0000ABCD, 32'h0,        1'b1, 3, 2, 3,   4};
    tv[7]  = '{1'b0, 3'b010, 32'h010, 32'h0,        32'h801122AB, 1'b0, 3, 1, 4,   0};
    tv[8]  = '{1'b0, 3'b101, 32'h00F, 32'h0,        32'h0000ABCD, 1'b1, 5, 2, 3,   4};
    tv[9]  = '{1'b0, 3'b001, 32'h00F, 32'h0,        32'hFFFFABCD, 1'b1, 5, 2, 3,   4};
    tv[10] = '{1'b0, 3'b010, 32'h7FD, 32'h0,        32'h55443322, 1'b1, 5, 2, 511, 0};
    tv[11] = '{1'b0, 3'b010, 32'h00E, 32'h0,        32'h22ABCDEE, 1'b1, 5, 2, 3,   4};
    tv[12] = '{1'b1, 3'b000, 32'h021, 32'h12345677, 32'h0,        1'b0, 2, 1, 8,   0};
    tv[13] = '{1'b0, 3'b010, 32'h020, 32'h0,        32'h00007700, 1'b0, 3, 1, 8,   0};
    tv[14] = '{1'b1, 3'b100, 32'h024, 32'hCAFEF00D, 32'h0,        1'b0, 2, 1, 9,   0};
    tv[15] = '{1'b0, 3'b011, 32'h024, 32'h0,        32'hCAFEF00D, 1'b0, 3, 1, 9,   0};
    tv[16] = '{1'b0, 3'b000, 32'h7FF, 32'h0,        32'h00000044, 1'b0, 3, 1, 511, 0};
    tv[17] = '{1'b1, 3'b010, 32'h7FE, 32'hA1B2C3D4, 32'h0,        1'b1, 3, 2, 511, 0};
    tv[18] = '{1'b0, 3'b010, 32'h7FE, 32'h0,        32'hA1B2C3D4, 1'b1, 5, 2, 511, 0};
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b0;
    chk("reset req_ready", 32'(ia.req_ready), 1);
    chk("reset rsp_valid", 32'(ia.rsp_valid), 0);
    chk("reset rsp_rdata", ia.rsp_rdata, 0);
    chk("reset strobes", {ia.dm_be, ia.dm_we, ia.dm_re, ia.rsp_misalign}, 0);
    chk("reset dm_addr", 32'(ia.dm_addr), 0);
    va = 1'b1; mr = 1'b0; mwr = 1'b0; addr = 32'h10;
    @(posedge clk); #1;
    va = 1'b0;
    chk("nop req_ready", 32'(ia.req_ready), 1);
    begin
      logic act = 1'b0;
      repeat (3) begin @(posedge clk); #1; act = act | ia.rsp_valid | ia.dm_re | ia.dm_we; end
      chk("nop no activity", 32'(act), 0);
    end
    for (int i = 0; i < 19; i++) begin
      run(1'b0, tv[i].wr, tv[i].f3, tv[i].addr, tv[i].wdata);
      chk($sformatf("v%0d rdata", i), r_rdata, tv[i].rdata);
      chk($sformatf("v%0d misalign", i), 32'(r_mis), 32'(tv[i].mis));
      chk($sformatf("v%0d latency", i), 32'(r_lat), 32'(tv[i].lat));
      chk($sformatf("v%0d accesses", i), 32'(r_n), 32'(tv[i].n));
      chk($sformatf("v%0d word0", i), r_a[0], 32'(tv[i].a0));
      if (tv[i].n == 2) chk($sformatf("v%0d word1", i), r_a[1], 32'(tv[i].a1));
    end
    run(1'b0, 1'b1, 3'b001, 32'h2F, 32'h0000ABCD);
    chk("sh split word0", r_a[0], 11);
    chk("sh split be0", 32'(r_be[0]), 32'h8);
    chk("sh split data0", 32'(r_d[0][31:24]), 32'hCD);
    chk("sh split word1", r_a[1], 12);
    chk("sh split be1", 32'(r_be[1]), 32'h1);
    chk("sh split data1", 32'(r_d[1][7:0]), 32'hAB);
    run(1'b1, 1'b1, 3'b010, 32'h02, 32'h12345678);
    chk("nosplit latency", 32'(r_lat), 2);
    chk("nosplit misalign", 32'(r_mis), 1);
    chk("nosplit rdata", r_rdata, 0);
    chk("nosplit strobes", 32'(r_n), 0);
    chk("nosplit ready low", 32'(r_low), 2);
    run(1'b1, 1'b1, 3'b010, 32'h04, 32'h12345678);
    chk("nosplit aligned latency", 32'(r_lat), 2);
    chk("nosplit aligned misalign", 32'(r_mis), 0);
    chk("nosplit aligned accesses", 32'(r_n), 1);
    @(negedge clk);
    sel = 1'b0; mr = 1'b1; mwr = 1'b0; f3 = 3'b010; addr = 32'h7FD; va = 1'b1;
    @(posedge clk); #1;
    va = 1'b0;
    @(posedge clk); #1;
    chk("mid dm_re before reset", 32'(ia.dm_re), 1);
    chk("mid dm_addr before reset", 32'(ia.dm_addr), 511);
    #2 reset = 1'b1;
    #1;
    chk("mid reset dm_re", 32'(ia.dm_re), 0);
    chk("mid reset rsp_valid", 32'(ia.rsp_valid), 0);
    chk("mid reset req_ready", 32'(ia.req_ready), 1);
    @(posedge clk);
    @(negedge clk) reset = 1'b0;
    run(1'b0, 1'b0, 3'b010, 32'h10, 32'h0);
    chk("post reset lw rdata", r_rdata, 32'hDEADBEEF);
    chk("post reset lw latency", 32'(r_lat), 3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
